nfca_rx_session_ctrl: RTL and testbench

//  Sequences one NFC-A PICC->PCD receive session around the RX bit-to-byte parser. Holds the parser in reset until the
//  PCD TX frame ends, then releases it with the configured remainb. Runs a response timeout and forwards parsed

---
 rtl/nfca_rx_session_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_nfca_rx_session_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfca_rx_session_ctrl.sv
// NFC-A PICC->PCD receive session sequencer: holds/releases the RX parser, runs the response
// timeout, forwards parsed bytes, checks CRC_A and reports one status per session.
module nfca_rx_session_ctrl #(
    parameter int unsigned TIMEOUT_W      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 400000,
    parameter int unsigned MAX_BYTES      = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_start,
    input  logic [2:0] req_remainb,
    input  logic       req_crc_en,
    input  logic       req_abort,
    input  logic       tx_done,
    output logic       rx_prs_rstn,
    output logic [2:0] rx_prs_remainb,
    input  logic       rx_tvalid,
    input  logic [7:0] rx_tdata,
    input  logic [3:0] rx_tdatab,
    input  logic       rx_tend,
    input  logic       rx_terr,
    output logic       out_tvalid,
    output logic [7:0] out_tdata,
    output logic [3:0] out_tdatab,
    output logic       busy,
    output logic       done,
    output logic [2:0] sts_code,
    output logic [6:0] sts_bytes
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TX,
        S_LISTEN,
        S_RECV,
        S_FINISH
    } state_t;

    localparam logic [2:0] STS_OK      = 3'd0;
    localparam logic [2:0] STS_TIMEOUT = 3'd1;
    localparam logic [2:0] STS_COLL    = 3'd2;
    localparam logic [2:0] STS_PARSE   = 3'd3;
    localparam logic [2:0] STS_CRC     = 3'd4;
    localparam logic [2:0] STS_OVF     = 3'd5;
    localparam logic [2:0] STS_ABORT   = 3'd6;

    localparam logic [15:0]          CRC_INIT   = 16'h6363;
    localparam logic [15:0]          CRC_POLY   = 16'h8408;
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]           BYTES_MAX  = 7'(MAX_BYTES);
    localparam logic [6:0]           BYTES_SAT  = 7'h7F;

    state_t               state;
    logic [TIMEOUT_W-1:0] timer;
    logic [15:0]          crc;
    logic                 crc_en;
    logic                 col;

    logic       fin;
    logic [2:0] fin_code;
    logic       fwd;
    logic       take;
    logic       part;

    // Reflected CRC_A update over one byte, LSB first
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Per-cycle event decode; abort outranks any same-cycle word or timeout
    always_comb begin
        fin      = 1'b0;
        fin_code = STS_OK;
        fwd      = 1'b0;
        take     = 1'b0;
        part     = 1'b0;
        if (state == S_WAIT_TX) begin
            if (req_abort) begin
                fin      = 1'b1;
                fin_code = STS_ABORT;
            end
        end else if (state == S_LISTEN || state == S_RECV) begin
            if (req_abort) begin
                fin      = 1'b1;
                fin_code = STS_ABORT;
            end else if (rx_tvalid) begin
                if (rx_tend) begin
                    fin = 1'b1;
                    if (rx_terr) begin
                        fwd      = (rx_tdatab != 4'd0);
                        fin_code = STS_PARSE;
                    end else if (col) begin
                        fin_code = STS_COLL;
                    end else if (crc_en && (sts_bytes < 7'd3 || crc != 16'h0000)) begin
                        fin_code = STS_CRC;
                    end else begin
                        fin_code = STS_OK;
                    end
                end else if (rx_tdatab == 4'd8) begin
                    if (sts_bytes == BYTES_MAX) begin
                        fin      = 1'b1;
                        fin_code = STS_OVF;
                    end else begin
                        fwd  = 1'b1;
                        take = 1'b1;
                    end
                end else if (rx_tdatab != 4'd0 && rx_tdatab < 4'd8) begin
                    fwd  = 1'b1;
                    part = 1'b1;
                end
            end else if (state == S_LISTEN && timer == TIMER_LAST) begin
                fin      = 1'b1;
                fin_code = STS_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            timer          <= '0;
            crc            <= CRC_INIT;
            crc_en         <= 1'b0;
            col            <= 1'b0;
            rx_prs_rstn    <= 1'b0;
            rx_prs_remainb <= 3'd0;
            out_tvalid     <= 1'b0;
            out_tdata      <= 8'd0;
            out_tdatab     <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sts_code       <= 3'd0;
            sts_bytes      <= 7'd0;
        end else begin
            out_tvalid <= fwd;
            done       <= fin;
            if (fwd) begin
                out_tdata  <= rx_tdata;
                out_tdatab <= rx_tdatab;
            end
            if (take) begin
                crc <= crc_byte(crc, rx_tdata);
                if (sts_bytes != BYTES_SAT) sts_bytes <= sts_bytes + 7'd1;
            end
            if (part) col <= 1'b1;
            if (fin) begin
                state       <= S_FINISH;
                sts_code    <= fin_code;
                rx_prs_rstn <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_start) begin
                            state          <= S_WAIT_TX;
                            busy           <= 1'b1;
                            rx_prs_remainb <= req_remainb;
                            crc_en         <= req_crc_en;
                            crc            <= CRC_INIT;
                            sts_bytes      <= 7'd0;
                            col            <= 1'b0;
                        end
                    end
                    S_WAIT_TX: begin
                        if (tx_done) begin
                            state       <= S_LISTEN;
                            rx_prs_rstn <= 1'b1;
                            timer       <= '0;
                        end
                    end
                    S_LISTEN: begin
                        timer <= timer + TIMEOUT_W'(1);
                        if (rx_tvalid) state <= S_RECV;
                    end
                    S_RECV: begin
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        rx_prs_rstn <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nfca_rx_session_ctrl.sv
// Self-checking bench for nfca_rx_session_ctrl: directed sessions plus randomized sessions
// compared against a transaction-level model of the session rules.
module tb_nfca_rx_session_ctrl;

    localparam int unsigned TO_CYC = 100;
    localparam int unsigned MAXB   = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_start = 1'b0;
    logic [2:0] req_remainb = 3'd0;
    logic       req_crc_en = 1'b0;
    logic       req_abort = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_prs_rstn;
    logic [2:0] rx_prs_remainb;
    logic       rx_tvalid = 1'b0;
    logic [7:0] rx_tdata = 8'd0;
    logic [3:0] rx_tdatab = 4'd0;
    logic       rx_tend = 1'b0;
    logic       rx_terr = 1'b0;
    logic       out_tvalid;
    logic [7:0] out_tdata;
    logic [3:0] out_tdatab;
    logic       busy;
    logic       done;
    logic [2:0] sts_code;
    logic [6:0] sts_bytes;

    nfca_rx_session_ctrl #(
        .TIMEOUT_W     (20),
        .TIMEOUT_CYCLES(TO_CYC),
        .MAX_BYTES     (MAXB)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_start     (req_start),
        .req_remainb   (req_remainb),
        .req_crc_en    (req_crc_en),
        .req_abort     (req_abort),
        .tx_done       (tx_done),
        .rx_prs_rstn   (rx_prs_rstn),
        .rx_prs_remainb(rx_prs_remainb),
        .rx_tvalid     (rx_tvalid),
        .rx_tdata      (rx_tdata),
        .rx_tdatab     (rx_tdatab),
        .rx_tend       (rx_tend),
        .rx_terr       (rx_terr),
        .out_tvalid    (out_tvalid),
        .out_tdata     (out_tdata),
        .out_tdatab    (out_tdatab),
        .busy          (busy),
        .done          (done),
        .sts_code      (sts_code),
        .sts_bytes     (sts_bytes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] b;
        bit         tend;
        bit         terr;
    } word_t;

    word_t       stim[$];
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [2:0]  exp_code;
    logic [6:0]  exp_bytes;
    logic [2:0]  got_code;
    logic [6:0]  got_bytes;
    int          done_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    // Record forwarded words and done pulses away from the active edge
    always @(negedge clk) begin
        if (out_tvalid === 1'b1) got_q.push_back({out_tdata, out_tdatab});
        if (done === 1'b1) begin
            done_cnt++;
            got_code  = sts_code;
            got_bytes = sts_bytes;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_a(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'h6363;
        foreach (q[k]) begin
            for (int j = 0; j < 8; j++) begin
                if ((c[0] ^ q[k][j]) == 1'b1) c = (c >> 1) ^ 16'h8408;
                else                          c = c >> 1;
            end
        end
        return c;
    endfunction

    // Session-level reference: walk the word list and apply the status rules
    task automatic model(input bit crc_en, input int abort_idx, input bit abort_wait);
        logic [7:0] full[$];
        bit col;
        int code;
        col  = 0;
        code = -1;
        exp_q.delete();
        if (abort_wait) code = 6;
        for (int i = 0; i < stim.size() && code < 0; i++) begin
            if (i == abort_idx) begin
                code = 6;
            end else if (stim[i].tend) begin
                if (stim[i].terr) begin
                    if (stim[i].b != 0) exp_q.push_back({stim[i].d, stim[i].b});
                    code = 3;
                end else if (col) code = 2;
                else if (crc_en && (full.size() < 3 || crc_a(full) != 16'h0000)) code = 4;
                else code = 0;
            end else if (stim[i].b == 4'd8) begin
                if (full.size() == MAXB) code = 5;
                else begin
                    full.push_back(stim[i].d);
                    exp_q.push_back({stim[i].d, 4'd8});
                end
            end else if (stim[i].b != 0 && stim[i].b < 8) begin
                exp_q.push_back({stim[i].d, stim[i].b});
                col = 1;
            end
        end
        if (code < 0) code = 1;
        exp_code  = 3'(code);
        exp_bytes = 7'(full.size());
    endtask

    task automatic run_session(input string name, input bit crc_en, input logic [2:0] rem,
                               input int abort_idx, input int start_idx, input bit abort_wait);
        int n;
        model(crc_en, abort_idx, abort_wait);
        got_q.delete();
        done_cnt    = 0;
        req_start   = 1'b1;
        req_remainb = rem;
        req_crc_en  = crc_en;
        step();
        req_start   = 1'b0;
        req_remainb = 3'($urandom);
        req_crc_en  = 1'($urandom);
        checks++;
        if (busy !== 1'b1 || rx_prs_rstn !== 1'b0 || rx_prs_remainb !== rem) begin
            errors++;
            $display("FAIL %s open: busy=%b prs_rstn=%b remainb=%0d want 1 0 %0d",
                     name, busy, rx_prs_rstn, rx_prs_remainb, rem);
        end
        repeat ($urandom_range(0, 3)) step();
        if (abort_wait) begin
            req_abort = 1'b1;
            step();
            req_abort = 1'b0;
        end else begin
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++;
            if (rx_prs_rstn !== 1'b1) begin
                errors++;
                $display("FAIL %s release: prs_rstn=%b want 1", name, rx_prs_rstn);
            end
            repeat ($urandom_range(0, 10)) step();
            for (int i = 0; i < stim.size(); i++) begin
                rx_tvalid = 1'b1;
                rx_tdata  = stim[i].d;
                rx_tdatab = stim[i].b;
                rx_tend   = stim[i].tend;
                rx_terr   = stim[i].terr;
                req_abort = (i == abort_idx);
                req_start = (i == start_idx);
                step();
                rx_tvalid = 1'b0;
                req_abort = 1'b0;
                req_start = 1'b0;
                rx_tdata  = 8'($urandom);
                rx_tdatab = 4'($urandom);
                rx_tend   = 1'($urandom);
                rx_terr   = 1'($urandom);
                repeat ($urandom_range(0, 2)) step();
            end
        end
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (got_code !== exp_code) begin
            errors++;
            $display("FAIL %s sts_code: got %0d want %0d", name, got_code, exp_code);
        end
        checks++;
        if (got_bytes !== exp_bytes) begin
            errors++;
            $display("FAIL %s sts_bytes: got %0d want %0d", name, got_bytes, exp_bytes);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s out_count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL %s out[%0d]: got %h/%0d want %h/%0d", name, k,
                             got_q[k][11:4], got_q[k][3:0], exp_q[k][11:4], exp_q[k][3:0]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || rx_prs_rstn !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b prs_rstn=%b want 0 0", name, busy, rx_prs_rstn);
        end
    endtask

    function automatic word_t w(input logic [7:0] d, input logic [3:0] b, input bit te, input bit tr);
        word_t x;
        x.d = d; x.b = b; x.tend = te; x.terr = tr;
        return x;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({rx_prs_rstn, rx_prs_remainb, out_tvalid, out_tdata, out_tdatab, busy, done,
             sts_code, sts_bytes} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {rx_prs_rstn, rx_prs_remainb, out_tvalid,
                     out_tdata, out_tdatab, busy, done, sts_code, sts_bytes});
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        stim = '{w(8'h44, 4'd8, 0, 0), w(8'h00, 4'd8, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("basic", 1'b0, 3'd0, -1, -1, 1'b0);
    endtask

    task automatic test_crc();
        stim = '{w(8'h08, 4'd8, 0, 0), w(8'hB6, 4'd8, 0, 0), w(8'hDD, 4'd8, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("crc_ok", 1'b1, 3'd5, -1, -1, 1'b0);
        stim = '{w(8'h08, 4'd8, 0, 0), w(8'hB6, 4'd8, 0, 0), w(8'hDC, 4'd8, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("crc_bad", 1'b1, 3'd2, -1, -1, 1'b0);
        stim = '{w(8'h12, 4'd8, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("crc_short", 1'b1, 3'd0, -1, -1, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        done_cnt  = 0;
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n != TO_CYC) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO_CYC);
        end
        checks++;
        if (sts_code !== 3'd1 || sts_bytes !== 7'd0 || rx_prs_rstn !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: code=%0d bytes=%0d prs_rstn=%b want 1 0 0",
                     sts_code, sts_bytes, rx_prs_rstn);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_collision();
        stim = '{w(8'h93, 4'd8, 0, 0), w(8'h05, 4'd3, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("collision", 1'b1, 3'd3, -1, -1, 1'b0);
    endtask

    task automatic test_overflow();
        stim = '{w(8'h01, 4'd8, 0, 0), w(8'h02, 4'd8, 0, 0), w(8'h03, 4'd8, 0, 0),
                 w(8'h04, 4'd8, 0, 0), w(8'h05, 4'd8, 0, 0), w(8'hAA, 4'd4, 1, 1)};
        run_session("overflow", 1'b0, 3'd0, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        stim = '{w(8'h11, 4'd8, 0, 0), w(8'h22, 4'd8, 0, 0), w(8'h33, 4'd8, 0, 0), w(8'h00, 4'd0, 1, 0)};
        run_session("abort_recv", 1'b1, 3'd1, 2, 1, 1'b0);
        stim.delete();
        run_session("abort_wait_tx", 1'b0, 3'd7, -1, -1, 1'b1);
        stim = '{w(8'h7E, 4'd6, 1, 1)};
        run_session("parse_err", 1'b0, 3'd6, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        int k;
        logic [7:0] fq[$];
        logic [15:0] c;
        for (int s = 0; s < 40; s++) begin
            stim.delete();
            fq.delete();
            k = $urandom_range(0, 6);
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 5) == 0) stim.push_back(w(8'($urandom), 4'($urandom_range(1, 7)), 0, 0));
                fq.push_back(8'($urandom));
                stim.push_back(w(fq[fq.size()-1], 4'd8, 0, 0));
            end
            if (k >= 1 && k <= 3 && $urandom_range(0, 1) == 1) begin
                c = crc_a(fq);
                stim.push_back(w(c[7:0], 4'd8, 0, 0));
                stim.push_back(w(c[15:8], 4'd8, 0, 0));
            end
            if ($urandom_range(0, 4) == 0) stim.push_back(w(8'($urandom), 4'($urandom_range(0, 8)), 1, 1));
            else                           stim.push_back(w(8'($urandom), 4'd0, 1, 0));
            if ($urandom_range(0, 7) == 0) stim.delete();
            run_session("random", 1'($urandom), 3'($urandom),
                        ($urandom_range(0, 5) == 0 && stim.size() > 0) ? $urandom_range(0, stim.size() - 1) : -1,
                        -1, ($urandom_range(0, 15) == 0));
        end
    endtask

    task automatic test_async_reset();
        done_cnt  = 0;
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        tx_done   = 1'b1;
        step();
        tx_done   = 1'b0;
        rx_tvalid = 1'b1;
        rx_tdata  = 8'h5A;
        rx_tdatab = 4'd8;
        rx_tend   = 1'b0;
        rx_terr   = 1'b0;
        step();
        rx_tvalid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rx_prs_rstn !== 1'b0 || sts_bytes !== 7'd0 || out_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b prs_rstn=%b bytes=%0d out_tvalid=%b want 0 0 0 0",
                     busy, rx_prs_rstn, sts_bytes, out_tvalid);
        end
        repeat (3) step();
        rstn = 1'b1;
        repeat (3) step();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_done: done_count=%0d busy=%b want 0 0", done_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc();
        test_timeout();
        test_collision();
        test_overflow();
        test_abort();
        test_random();
        test_async_reset();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
